// File: rtl/msoc_debug_pkg.sv
// Shared types and constants for the multi-core debug command engine.
// Action codes mirror the OCI debug-slave action set.
package msoc_debug_pkg;

    localparam int JDO_W = 38;

    localparam logic [1:0] IR_OCIMEM = 2'b00;
    localparam logic [1:0] IR_BREAK  = 2'b10;
    localparam logic [1:0] IR_TRACE  = 2'b11;

    typedef enum logic [3:0] {
        ACT_NOP         = 4'd0,
        ACT_OCIMEM_A    = 4'd1,
        ACT_OCIMEM_B    = 4'd2,
        ACT_BREAK_A     = 4'd3,
        ACT_BREAK_B     = 4'd4,
        ACT_BREAK_C     = 4'd5,
        ACT_TRACECTRL   = 4'd6,
        ACT_NO_OCIMEM_A = 4'd9,
        ACT_NO_BREAK_A  = 4'd11,
        ACT_NO_BREAK_B  = 4'd12,
        ACT_NO_BREAK_C  = 4'd13
    } act_code_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Only jdo[37:34] and jdo[15] influence the action; callers pass just those.
    function automatic act_code_e decode_act(input logic [1:0] ir,
                                             input logic [3:0] jdo_hi,
                                             input logic       trace_bit);
        act_code_e code;
        code = ACT_NOP;
        case (ir)
            IR_OCIMEM: begin
                if (jdo_hi[1])      code = ACT_OCIMEM_B;
                else if (jdo_hi[0]) code = ACT_OCIMEM_A;
                else                code = ACT_NO_OCIMEM_A;
            end
            IR_BREAK: begin
                if (!jdo_hi[2])      code = jdo_hi[3] ? ACT_BREAK_A : ACT_NO_BREAK_A;
                else if (!jdo_hi[1]) code = jdo_hi[3] ? ACT_BREAK_B : ACT_NO_BREAK_B;
                else                 code = jdo_hi[3] ? ACT_BREAK_C : ACT_NO_BREAK_C;
            end
            IR_TRACE: code = trace_bit ? ACT_TRACECTRL : ACT_NOP;
            default:  code = ACT_NOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/msoc_debug_cmd_engine_if.sv
// Debug command bus: buffered update input from the JTAG front end and
// per-core action delivery with shared code/payload.
interface msoc_debug_cmd_engine_if
    import msoc_debug_pkg::*;
#(
    parameter int NUM_CORES = 2
);
    localparam int CW = $clog2(NUM_CORES + 1);

    logic                 upd_valid;
    logic                 upd_ready;
    logic [1:0]           upd_ir;
    logic [CW-1:0]        upd_core;
    logic [JDO_W-1:0]     upd_jdo;
    logic [NUM_CORES-1:0] act_valid;
    logic [NUM_CORES-1:0] act_ready;
    logic [3:0]           act_code;
    logic [JDO_W-1:0]     act_jdo;

    modport master (
        output upd_valid, upd_ir, upd_core, upd_jdo, act_ready,
        input  upd_ready, act_valid, act_code, act_jdo
    );

    modport slave (
        input  upd_valid, upd_ir, upd_core, upd_jdo, act_ready,
        output upd_ready, act_valid, act_code, act_jdo
    );
endinterface

// File: rtl/msoc_debug_cmd_fifo.sv
// Synchronous FIFO for buffered debug updates; DEPTH must be a power of two
// so the pointers wrap naturally. Push while full and pop while empty are ignored.
module msoc_debug_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42,
    localparam int LW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)      level_d = level_q + LW'(1);
        else if (!do_push && do_pop) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/msoc_debug_cmd_engine.sv
// Multi-core debug command engine: buffers IR/JDO updates, decodes them and
// delivers each action to one core or all cores. Optional abort: DBG_CMD_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | pop next buffered update, decode, drop NOP / bad-core commands
//   ISSUE | offer act_valid=pend_mask until every target core has accepted
module msoc_debug_cmd_engine
    import msoc_debug_pkg::*;
#(
    parameter int NUM_CORES   = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255,
    localparam int CW         = $clog2(NUM_CORES + 1),
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    msoc_debug_cmd_engine_if.slave    dbg,
    output logic [LW-1:0]             fifo_level,
    output logic                      cmd_err,
    input  logic                      err_clr
);

    localparam int            FW    = 2 + CW + JDO_W;
    localparam logic [CW-1:0] BCAST = CW'(NUM_CORES);

    logic [FW-1:0]        fifo_rdata;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [1:0]           head_ir;
    logic [CW-1:0]        head_core;
    logic [JDO_W-1:0]     head_jdo;
    act_code_e            head_code;
    logic [NUM_CORES-1:0] head_mask;

    state_e               state_q, state_d;
    logic [NUM_CORES-1:0] pend_q, pend_d;
    act_code_e            code_q, code_d;
    logic [JDO_W-1:0]     jdo_q, jdo_d;
    logic                 err_q, err_d;
    logic                 err_set;

    msoc_debug_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (dbg.upd_valid && dbg.upd_ready),
        .pop   (fifo_pop),
        .wdata ({dbg.upd_ir, dbg.upd_core, dbg.upd_jdo}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign {head_ir, head_core, head_jdo} = fifo_rdata;
    assign head_code = decode_act(head_ir, head_jdo[37:34], head_jdo[15]);

    always_comb begin
        head_mask = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            head_mask[i] = (head_core == CW'(i)) || (head_core == BCAST);
        end
    end

`ifdef DBG_CMD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        code_d   = code_q;
        jdo_d    = jdo_q;
        err_set  = 1'b0;
        fifo_pop = 1'b0;
`ifdef DBG_CMD_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    code_d   = head_code;
                    jdo_d    = head_jdo;
                    if (head_code != ACT_NOP) begin
                        if (head_core > BCAST) begin
                            err_set = 1'b1;
                        end else begin
                            pend_d  = head_mask;
                            state_d = ISSUE;
`ifdef DBG_CMD_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end
                end
            end
            ISSUE: begin
                pend_d = pend_q & ~dbg.act_ready;
                if (pend_d == '0) begin
                    state_d = IDLE;
`ifdef DBG_CMD_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    pend_d  = '0;
                    state_d = IDLE;
                    err_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over a simultaneous set so software never loses a clear.
        err_d = err_q;
        if (err_set) err_d = 1'b1;
        if (err_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            code_q  <= ACT_NOP;
            jdo_q   <= '0;
            err_q   <= 1'b0;
`ifdef DBG_CMD_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            jdo_q   <= jdo_d;
            err_q   <= err_d;
`ifdef DBG_CMD_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign dbg.upd_ready = !fifo_full;
    assign dbg.act_valid = pend_q;
    assign dbg.act_code  = code_q;
    assign dbg.act_jdo   = jdo_q;
    assign cmd_err       = err_q;

endmodule
